// File: rtl/ultratank_rom_loader_if.sv
// Download bus from hps_io (dn_*) and the registered ROM write port toward ultra_tank (rom_*).
interface ultratank_rom_loader_if;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data,
    input  rom_addr, rom_data, rom_we
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data,
    output rom_addr, rom_data, rom_we
  );
endinterface

// File: rtl/ultratank_rom_loader.sv
// Ultra Tank ROM download sequencer: region decode, one-hot write strobes, core reset ownership.
// Optional ROM_CHECKSUM_EN adds an 8-bit additive image checksum to the DRAIN verdict.
module ultratank_rom_loader #(
  parameter logic [15:0] PROG_BASE      = 16'h0000,
  parameter logic [15:0] PROG_SIZE      = 16'h2000,
  parameter logic [15:0] OBJ_BASE       = 16'h2000,
  parameter logic [15:0] OBJ_SIZE       = 16'h1000,
  parameter logic [15:0] PF_BASE        = 16'h3000,
  parameter logic [15:0] PF_SIZE        = 16'h0800,
  parameter logic [15:0] PROM_BASE      = 16'h3800,
  parameter logic [15:0] PROM_SIZE      = 16'h0020,
  parameter int unsigned RELEASE_CYCLES = 1024,
  parameter logic [7:0]  EXPECT_SUM     = 8'h00
) (
  input  logic                          clk_sys,
  input  logic                          Reset_n,
  ultratank_rom_loader_if.slave         bus,
  output logic                          core_reset_n,
  output logic                          load_done,
  output logic                          load_err,
  output logic [15:0]                   byte_cnt
);

  localparam int unsigned CW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [16:0] TOTAL = {1'b0, PROG_SIZE} + {1'b0, OBJ_SIZE}
                                + {1'b0, PF_SIZE} + {1'b0, PROM_SIZE};
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_RELEASE, S_RUN, S_ERROR
  } state_e;

  state_e        state_q;
  logic          dl_q;
  logic [3:0]    rom_we_q;
  logic [13:0]   rom_addr_q;
  logic [7:0]    rom_data_q;
  logic          core_reset_n_q, load_done_q, load_err_q;
  logic [15:0]   byte_cnt_q;
  logic [CW-1:0] rel_q;
`ifdef ROM_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif

  logic          hit_d, rise_d, pass_d;
  logic [3:0]    we_d;
  logic [13:0]   off_d;

  function automatic logic in_rgn(input logic [15:0] a, input logic [15:0] base,
                                  input logic [15:0] size);
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
  endfunction

  // Priority order PROG, OBJ, PF, PROM resolves any overlapping parameterisation.
  always_comb begin
    hit_d = 1'b0;
    we_d  = '0;
    off_d = '0;
    if (in_rgn(bus.dn_addr, PROG_BASE, PROG_SIZE)) begin
      hit_d = 1'b1; we_d = 4'b0001; off_d = 14'(bus.dn_addr - PROG_BASE);
    end else if (in_rgn(bus.dn_addr, OBJ_BASE, OBJ_SIZE)) begin
      hit_d = 1'b1; we_d = 4'b0010; off_d = 14'(bus.dn_addr - OBJ_BASE);
    end else if (in_rgn(bus.dn_addr, PF_BASE, PF_SIZE)) begin
      hit_d = 1'b1; we_d = 4'b0100; off_d = 14'(bus.dn_addr - PF_BASE);
    end else if (in_rgn(bus.dn_addr, PROM_BASE, PROM_SIZE)) begin
      hit_d = 1'b1; we_d = 4'b1000; off_d = 14'(bus.dn_addr - PROM_BASE);
    end
  end

  always_comb begin
    rise_d = bus.dn_download & ~dl_q;
`ifdef ROM_CHECKSUM_EN
    pass_d = ({1'b0, byte_cnt_q} == TOTAL) && (sum_q == EXPECT_SUM);
`else
    pass_d = ({1'b0, byte_cnt_q} == TOTAL);
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (!Reset_n) begin
      state_q        <= S_IDLE;
      dl_q           <= 1'b0;
      rom_we_q       <= '0;
      rom_addr_q     <= '0;
      rom_data_q     <= '0;
      core_reset_n_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
      byte_cnt_q     <= '0;
      rel_q          <= '0;
`ifdef ROM_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      dl_q     <= bus.dn_download;
      rom_we_q <= '0;
      if (rise_d || (state_q == S_IDLE && bus.dn_download)) begin
        state_q        <= S_LOAD;
        byte_cnt_q     <= '0;
        load_err_q     <= 1'b0;
        load_done_q    <= 1'b0;
        core_reset_n_q <= 1'b0;
`ifdef ROM_CHECKSUM_EN
        sum_q          <= '0;
`endif
      end else begin
        unique case (state_q)
          S_IDLE: core_reset_n_q <= 1'b0;
          S_LOAD: begin
            if (!bus.dn_download) begin
              state_q <= S_DRAIN;
            end else if (bus.dn_wr && hit_d) begin
              rom_we_q   <= we_d;
              rom_addr_q <= off_d;
              rom_data_q <= bus.dn_data;
              if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 16'd1;
`ifdef ROM_CHECKSUM_EN
              sum_q <= sum_q + bus.dn_data;
`endif
            end
          end
          S_DRAIN: begin
            rel_q <= '0;
            if (pass_d) begin
              state_q <= S_RELEASE;
            end else begin
              state_q    <= S_ERROR;
              load_err_q <= 1'b1;
            end
          end
          S_RELEASE: begin
            if (rel_q == REL_LAST) begin
              state_q        <= S_RUN;
              core_reset_n_q <= 1'b1;
              load_done_q    <= 1'b1;
            end else begin
              rel_q <= rel_q + 1'b1;
            end
          end
          S_RUN: ;
          S_ERROR: begin
            core_reset_n_q <= 1'b0;
            load_done_q    <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_data  = rom_data_q;
  assign core_reset_n  = core_reset_n_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign byte_cnt      = byte_cnt_q;

endmodule

// File: tb/tb_ultratank_rom_loader.sv
// Self-checking bench for ultratank_rom_loader: randomized images against a region/count model.
module tb_ultratank_rom_loader;
  localparam int unsigned RC      = 16;
  localparam logic [7:0]  EXP_SUM = 8'h00;
  localparam int unsigned TOTAL   = 'h3820;

  logic        clk_sys = 1'b0;
  logic        Reset_n = 1'b0;
  logic        core_reset_n, load_done, load_err;
  logic [15:0] byte_cnt;

  ultratank_rom_loader_if bus();

  ultratank_rom_loader #(.RELEASE_CYCLES(RC), .EXPECT_SUM(EXP_SUM)) dut (
    .clk_sys(clk_sys), .Reset_n(Reset_n), .bus(bus),
    .core_reset_n(core_reset_n), .load_done(load_done),
    .load_err(load_err), .byte_cnt(byte_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic [3:0] we; logic [13:0] addr; logic [7:0] data; } strobe_t;
  strobe_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  int          m_cnt = 0;
  logic [7:0]  m_sum = '0;
  bit          accepting = 0;
  int unsigned bases[4] = '{'h0000, 'h2000, 'h3000, 'h3800};
  int unsigned sizes[4] = '{'h2000, 'h1000, 'h0800, 'h0020};

  function automatic int region_of(input int unsigned a);
    for (int r = 0; r < 4; r++)
      if (a >= bases[r] && a < bases[r] + sizes[r]) return r;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  // Scoreboard: every strobe seen must match the oldest outstanding accepted byte.
  always begin
    @(posedge clk_sys); #1;
    if (bus.rom_we !== 4'b0000) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got we=%b addr=%h data=%h, required none",
                 bus.rom_we, bus.rom_addr, bus.rom_data);
      end else begin
        strobe_t e;
        e = exp_q.pop_front();
        if ({bus.rom_we, bus.rom_addr, bus.rom_data} !== e) begin
          errors++;
          $display("FAIL strobe: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                   bus.rom_we, bus.rom_addr, bus.rom_data, e.we, e.addr, e.data);
        end
      end
    end
  end

  task automatic write_byte(input int unsigned a, input logic [7:0] d);
    int r;
    strobe_t e;
    r = region_of(a);
    bus.dn_wr   = 1'b1;
    bus.dn_addr = 16'(a);
    bus.dn_data = d;
    if (r >= 0 && accepting) begin
      e.we   = 4'b0001 << r;
      e.addr = 14'(a - bases[r]);
      e.data = d;
      exp_q.push_back(e);
      m_cnt++;
      m_sum = m_sum + d;
    end
    tick();
    bus.dn_wr = 1'b0;
  endtask

  task automatic start_dl();
    bus.dn_download = 1'b1;
    m_cnt = 0;
    m_sum = '0;
    tick();
    accepting = 1;
    checks++;
    if ({core_reset_n, load_done, load_err, byte_cnt} !== {3'b000, 16'h0000}) begin
      errors++;
      $display("FAIL start_dl: got rst_n=%b done=%b err=%b cnt=%h, required 0 0 0 0000",
               core_reset_n, load_done, load_err, byte_cnt);
    end
  endtask

  task automatic end_dl();
    bit good;
    bus.dn_download = 1'b0;
    accepting = 0;
    tick();
    checks++;
    if (byte_cnt !== 16'(m_cnt) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_count: got cnt=%h pending=%0d, required cnt=%h pending=0",
               byte_cnt, exp_q.size(), 16'(m_cnt));
    end
`ifdef ROM_CHECKSUM_EN
    good = (m_cnt == TOTAL) && (m_sum == EXP_SUM);
`else
    good = (m_cnt == TOTAL);
`endif
    if (good) begin
      for (int k = 1; k <= RC + 1; k++) begin
        tick();
        if (k == RC) begin
          checks++;
          if (core_reset_n !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL release_hold: got rst_n=%b done=%b, required 0 0", core_reset_n, load_done);
          end
        end
      end
      checks++;
      if (core_reset_n !== 1'b1 || load_done !== 1'b1 || load_err !== 1'b0) begin
        errors++;
        $display("FAIL run: got rst_n=%b done=%b err=%b, required 1 1 0",
                 core_reset_n, load_done, load_err);
      end
    end else begin
      tick(); tick();
      checks++;
      if (load_err !== 1'b1 || core_reset_n !== 1'b0 || load_done !== 1'b0) begin
        errors++;
        $display("FAIL error_state: got err=%b rst_n=%b done=%b, required 1 0 0",
                 load_err, core_reset_n, load_done);
      end
    end
  endtask

  // gap: 0 back-to-back, 1 one idle cycle per byte, 2 occasional random idle.
  task automatic load_image(input int unsigned len, input int gap, input bit extra,
                            input logic [7:0] target);
    logic [7:0] d;
    for (int unsigned a = 0; a < len; a++) begin
      d = 8'($urandom);
      if (a == len - 1) d = target - m_sum;
      write_byte(a, d);
      if (gap == 1) tick();
      else if (gap == 2 && $urandom_range(0, 7) == 0) tick();
    end
    if (extra)
      for (int unsigned a = 'h3820; a < 'h4000; a++) begin
        write_byte(a, 8'($urandom));
        if ($urandom_range(0, 7) == 0) tick();
      end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.rom_we, bus.rom_addr, bus.rom_data, core_reset_n, load_done, load_err, byte_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: got we=%b addr=%h data=%h rst_n=%b done=%b err=%b cnt=%h, required all 0",
               bus.rom_we, bus.rom_addr, bus.rom_data, core_reset_n, load_done, load_err, byte_cnt);
    end
    Reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (core_reset_n !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL idle: got rst_n=%b done=%b, required 0 0", core_reset_n, load_done);
    end
  endtask

  task automatic test_full_image();
    strobes = 0;
    start_dl();
    load_image(TOTAL, 1, 0, EXP_SUM);
    end_dl();
    checks++;
    if (strobes != 14368) begin
      errors++;
      $display("FAIL strobe_count: got %0d, required 14368", strobes);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] d0, d1;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    start_dl();
    write_byte('h1FFF, d0);
    checks++;
    if (bus.rom_we !== 4'b0001 || bus.rom_addr !== 14'h1FFF || bus.rom_data !== d0) begin
      errors++;
      $display("FAIL boundary_prog: got we=%b addr=%h, required 0001 1fff", bus.rom_we, bus.rom_addr);
    end
    write_byte('h2000, d1);
    checks++;
    if (bus.rom_we !== 4'b0010 || bus.rom_addr !== 14'h0000 || bus.rom_data !== d1) begin
      errors++;
      $display("FAIL boundary_obj: got we=%b addr=%h, required 0010 0000", bus.rom_we, bus.rom_addr);
    end
    write_byte('h3820, 8'h11);
    write_byte('hFFFF, 8'h22);
    checks++;
    if (bus.rom_we !== 4'b0000 || byte_cnt !== 16'd2) begin
      errors++;
      $display("FAIL boundary_miss: got we=%b cnt=%h, required 0000 0002", bus.rom_we, byte_cnt);
    end
    end_dl();
  endtask

  task automatic test_outside_ignored();
    write_byte('h0010, 8'h5A);
    tick();
    checks++;
    if (bus.rom_we !== 4'b0000 || byte_cnt !== 16'd2 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL outside_load: got we=%b cnt=%h err=%b, required 0000 0002 1",
               bus.rom_we, byte_cnt, load_err);
    end
  endtask

  task automatic test_truncated();
    start_dl();
    load_image('h3000, 0, 0, 8'($urandom));
    end_dl();
    checks++;
    if (byte_cnt !== 16'h3000) begin
      errors++;
      $display("FAIL truncated_cnt: got %h, required 3000", byte_cnt);
    end
  endtask

  task automatic test_mid_reset();
    start_dl();
    for (int unsigned a = 0; a < 100; a++) write_byte(a * 3, 8'($urandom));
    tick();
    checks++;
    if (byte_cnt !== 16'd100) begin
      errors++;
      $display("FAIL mid_count: got %h, required 0064", byte_cnt);
    end
    Reset_n = 1'b0;
    bus.dn_download = 1'b0;
    accepting = 0;
    tick();
    checks++;
    if ({bus.rom_we, bus.rom_addr, bus.rom_data, core_reset_n, load_done, load_err, byte_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got we=%b addr=%h data=%h rst_n=%b done=%b err=%b cnt=%h, required all 0",
               bus.rom_we, bus.rom_addr, bus.rom_data, core_reset_n, load_done, load_err, byte_cnt);
    end
    Reset_n = 1'b1;
    tick();
    start_dl();
    load_image(TOTAL, 0, 0, EXP_SUM);
    end_dl();
  endtask

`ifdef ROM_CHECKSUM_EN
  task automatic test_checksum_bad();
    start_dl();
    load_image(TOTAL, 0, 0, 8'h5A);
    end_dl();
  endtask
`endif

  task automatic test_out_of_map();
    start_dl();
    load_image(TOTAL, 2, 1, EXP_SUM);
    end_dl();
    checks++;
    if (byte_cnt !== 16'h3820) begin
      errors++;
      $display("FAIL out_of_map_cnt: got %h, required 3820", byte_cnt);
    end
  endtask

  initial begin
    bus.dn_download = 1'b0;
    bus.dn_wr       = 1'b0;
    bus.dn_addr     = '0;
    bus.dn_data     = '0;
    test_reset();
    test_full_image();
    test_boundary();
    test_outside_ignored();
    test_truncated();
    test_mid_reset();
`ifdef ROM_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_out_of_map();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
